seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative restoring integer divider providing the divide path for fnSelect 111.
- Computes quotient and remainder of dividend / divisor, one quotient bit per cycle, with signed and unsigned modes and RISC-V divide-by-zero/overflow semantics.
- Sits beside the combinational ALU; the datapath controller launches it with start and stalls on busy until done.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
- clk  input  1  single system clock, rising-edge
- rst  input  1  synchronous reset, active-high
- start  input  1  launch request; sampled only in IDLE
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned; captured with start
- dividend  input  WIDTH  numerator; captured with start
- divisor  input  WIDTH  denominator; captured with start
- busy  output  1  high while an operation is in flight (LOAD through FIX)
- done  output  1  one-cycle pulse: quotient/remainder valid this cycle and held afterwards
- quotient  output  WIDTH  result quotient, held until next accepted start
- remainder  output  WIDTH  result remainder, held until next accepted start
- div_by_zero  output  1  set with done when divisor == 0; held with results

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and working registers cleared.
- States: IDLE, LOAD, RUN, FIX, DONE.
- IDLE: if start=1, capture operands and signed_op -> LOAD. Otherwise hold.
- LOAD:
  - If divisor==0: quotient=all ones, remainder=original dividend, div_by_zero=1 -> DONE.
  - Else: form magnitudes. In signed mode, negate negative operands; magnitude is treated as WIDTH-bit unsigned, so the most-negative value is 2^(WIDTH-1), which fits.
  - Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend); both are 0 in unsigned mode.
  - Clear the partial remainder, set counter=WIDTH -> RUN.
- RUN (exactly WIDTH cycles), each cycle:
  - Shift {rem, dvd} left by 1.
  - trial = rem_shifted - divisor_mag, computed WIDTH+1 bits wide.
  - If trial is non-negative, rem = trial and quotient LSB = 1; else keep rem and quotient LSB = 0.
  - Decrement counter; at counter==1 -> FIX.
- FIX:
  - quotient = q_neg ? -q : q; remainder = r_neg ? -r : r (mod 2^WIDTH).
  - Signed overflow (-2^(WIDTH-1) / -1) naturally yields quotient=-2^(WIDTH-1), remainder=0, div_by_zero=0.
  - -> DONE.
- DONE: done=1 for exactly this cycle, busy=0 -> IDLE. A start in DONE is ignored; start is accepted from the following IDLE cycle.
- busy: high in LOAD, RUN and FIX only.
- Latency, with start accepted at cycle 0:
  - Normal: done at cycle WIDTH+3 (LOAD=1, RUN=WIDTH, FIX=1, DONE=1).
  - Divide-by-zero: done at cycle 2.
- Output timing: quotient, remainder and div_by_zero update only on the cycle done is asserted, then hold. They do not change during RUN.
- start while busy or in DONE: ignored, no queuing.
- Input changes after capture: no effect on the result.
- Reset mid-operation: immediate return to IDLE, all outputs cleared, operation abandoned; no done pulse.
- Back-to-back: the minimum gap between accepted starts is WIDTH+4 cycles for normal ops.

Decomposition:
- Shared package div_pkg:
  - state enum typedef (IDLE, LOAD, RUN, FIX, DONE)
  - localparam for the divide-by-zero quotient (all ones)
  - WIDTH default constant shared with the ALU
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, dvd_msb, divisor_mag.
  - Outputs: next_rem, q_bit.
  - Instantiated once inside RUN.

Test Plan:
- Unsigned: start with dividend=200, divisor=7, signed_op=0 -> done at cycle 11, quotient=28, remainder=4, div_by_zero=0, busy high cycles 1-10.
- Signed: dividend=-7 (0xF9), divisor=2, signed_op=1 -> quotient=-3 (0xFD), remainder=-1 (0xFF). Also dividend=7, divisor=-2 -> quotient=0xFD, remainder=1.
- Divide-by-zero: dividend=0x5A, divisor=0, either mode -> done at cycle 2, quotient=0xFF, remainder=0x5A, div_by_zero=1.
- Signed overflow: dividend=0x80, divisor=0xFF, signed_op=1 -> quotient=0x80, remainder=0x00, div_by_zero=0. The same operands unsigned -> quotient=0x00, remainder=0x80.
- Protocol: start pulsed again at cycles 3 and 11 (in DONE), with operand changes, during 100/9 -> result 11 r 1 unaffected, both starts ignored, done pulses once for exactly one cycle, outputs held until next accepted start.
- Reset mid-op: rst asserted at cycle 5 of 255/16 -> next cycle busy=0, done=0, outputs=0, no done pulse. A fresh 255/16 then yields 15 r 15.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state type and
// width/result constants shared with the ALU.
package div_pkg;

  localparam int unsigned DefaultWidth = 8;

  // Divide-by-zero quotient is all ones; replicated to the instance width.
  localparam logic DivZeroFill = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor magnitude if it fits.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor_mag always holds, so the top bit of trial is a valid sign.
  always_comb begin
    shifted  = {rem, dvd_msb};
    trial    = shifted - {1'b0, divisor_mag};
    q_bit    = ~trial[WIDTH];
    next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned,
// with divide-by-zero returning all-ones quotient and the dividend as remainder.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e           state_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic             signed_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dmag_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [CNT_W-1:0] cnt_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // Magnitudes are WIDTH-bit unsigned so the most-negative value still fits.
  always_comb begin
    dvd_neg = signed_q & dividend_q[WIDTH-1];
    dvs_neg = signed_q & divisor_q[WIDTH-1];
    dvd_mag = dvd_neg ? -dividend_q : dividend_q;
    dvs_mag = dvs_neg ? -divisor_q : divisor_q;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem        (rem_q),
    .dvd_msb    (dvd_q[WIDTH-1]),
    .divisor_mag(dmag_q),
    .next_rem   (step_rem),
    .q_bit      (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dividend_q  <= '0;
      divisor_q   <= '0;
      signed_q    <= 1'b0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dmag_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            dividend_q <= dividend;
            divisor_q  <= divisor;
            signed_q   <= signed_op;
            busy       <= 1'b1;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          if (divisor_q == '0) begin
            quotient    <= {WIDTH{DivZeroFill}};
            remainder   <= dividend_q;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_q     <= StDone;
          end else begin
            dvd_q   <= dvd_mag;
            dmag_q  <= dvs_mag;
            rem_q   <= '0;
            q_neg_q <= dvd_neg ^ dvs_neg;
            r_neg_q <= dvd_neg;
            cnt_q   <= CNT_W'(WIDTH);
            state_q <= StRun;
          end
        end
        StRun: begin
          // Quotient bits shift into dvd_q as the dividend bits shift out.
          rem_q <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quotient    <= q_neg_q ? -dvd_q : dvd_q;
          remainder   <= r_neg_q ? -rem_q : rem_q;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases, protocol and
// reset scenarios, then random operands against an arithmetic reference.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total;
  int bad;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    int sa;
    int sb;
    int qi;
    int ri;
    dz = 1'b0;
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[W-1:0];
      r  = ri[W-1:0];
    end
  endfunction

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    int           cyc;
    ref_div(s, a, b, eq, er, edz);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    step();
    start     = 1'b0;
    // Scramble inputs after capture; the result must not depend on them.
    signed_op = 1'($urandom);
    dividend  = W'($urandom);
    divisor   = W'($urandom);
    cyc = 1;
    while (!done && cyc < 40) begin
      check("busy_inflight", 32'(busy), 32'd1);
      check("q_held_inflight", 32'(quotient), 32'(last_q));
      step();
      cyc++;
    end
    check("latency", 32'(cyc), edz ? 32'd2 : 32'(W + 3));
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edz));
    check("busy_at_done", 32'(busy), 32'd0);
    last_q = eq;
    last_r = er;
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("q_held_after", 32'(quotient), 32'(eq));
    check("r_held_after", 32'(remainder), 32'(er));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    last_q    = '0;
    last_r    = '0;
    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    step();

    // Directed cases from the plan.
    run_op(1'b0, 8'd200, 8'd7);
    run_op(1'b1, 8'hF9, 8'd2);
    run_op(1'b1, 8'd7, 8'hFE);
    run_op(1'b0, 8'h5A, 8'h00);
    run_op(1'b1, 8'h5A, 8'h00);
    run_op(1'b1, 8'h80, 8'hFF);
    run_op(1'b0, 8'h80, 8'hFF);
    run_op(1'b1, 8'h80, 8'h80);
    run_op(1'b0, 8'hFF, 8'h01);

    // Protocol: extra starts mid-op and in DONE are ignored.
    signed_op = 1'b0;
    dividend  = 8'd100;
    divisor   = 8'd9;
    start     = 1'b1;
    step();
    for (int cyc = 1; cyc < 11; cyc++) begin
      if (cyc == 3) begin
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 8'd5;
        divisor   = 8'd1;
      end else begin
        start = 1'b0;
      end
      check("proto_busy", 32'(busy), 32'd1);
      check("proto_no_done", 32'(done), 32'd0);
      step();
    end
    check("proto_done", 32'(done), 32'd1);
    check("proto_q", 32'(quotient), 32'd11);
    check("proto_r", 32'(remainder), 32'd1);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd3;
    step();
    start = 1'b0;
    check("proto_pulse", 32'(done), 32'd0);
    check("proto_ignored", 32'(busy), 32'd0);
    check("proto_q_held", 32'(quotient), 32'd11);
    check("proto_r_held", 32'(remainder), 32'd1);
    step();
    check("proto_idle", 32'(busy), 32'd0);
    last_q = 8'd11;
    last_r = 8'd1;

    // Reset mid-operation abandons the op with no done pulse.
    signed_op = 1'b0;
    dividend  = 8'd255;
    divisor   = 8'd16;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 5; cyc++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_q", 32'(quotient), 32'd0);
    check("mid_rst_r", 32'(remainder), 32'd0);
    check("mid_rst_dz", 32'(div_by_zero), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("mid_rst_no_done", 32'(done), 32'd0);
      step();
    end
    last_q = '0;
    last_r = '0;
    run_op(1'b0, 8'd255, 8'd16);

    // Random operands, occasionally forcing zero or extreme divisors.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) b = 8'hFF;
      if ($urandom_range(0, 7) == 0) a = 8'h80;
      run_op(1'($urandom), a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
